cv32e40p_pc_redirect_unit: RTL and testbench

- Parametrised next-generation PC-redirect generator between the controller/CSR file and the prefetch stage.
- Selects the redirect target from boot, jump, branch, trap, xRET, debug, fence.i and hwloop sources, over NUM_PRIV trap levels.
- Registers the target and holds it in a valid/ready handshake until the fetch stage accepts it.
- Issues an automatic boot redirect after reset and drives the mtvec-init strobe.

---
 rtl/cv32e40p_pc_redirect_unit.sv | 204 ++++++++++++++++++++
 tb/tb_cv32e40p_pc_redirect_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_pc_redirect_unit.sv
// PC redirect generator: selects the next fetch target and holds it in a
// valid/ready handshake towards the prefetch stage.
module cv32e40p_pc_redirect_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int VEC_W      = 5,
    parameter int NUM_PRIV   = 2,
    parameter int PRIV_W     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pc_set_i,
    input  logic [3:0]                       pc_mux_i,
    input  logic [2:0]                       exc_pc_mux_i,
    input  logic [PRIV_W-1:0]                trap_priv_i,
    input  logic [PRIV_W-1:0]                xret_priv_i,
    input  logic [NUM_PRIV*(ADDR_WIDTH-VEC_W-3)-1:0] trap_base_addr_i,
    input  logic [NUM_PRIV*VEC_W-1:0]        exc_vec_i,
    input  logic [NUM_PRIV*ADDR_WIDTH-1:0]   epc_i,
    input  logic [ADDR_WIDTH-1:0]            boot_addr_i,
    input  logic [ADDR_WIDTH-1:0]            dm_halt_addr_i,
    input  logic [ADDR_WIDTH-1:0]            dm_exception_addr_i,
    input  logic [ADDR_WIDTH-1:0]            jump_target_id_i,
    input  logic [ADDR_WIDTH-1:0]            jump_target_ex_i,
    input  logic [ADDR_WIDTH-1:0]            depc_i,
    input  logic [ADDR_WIDTH-1:0]            pc_id_i,
    input  logic [ADDR_WIDTH-1:0]            hwlp_target_i,
    input  logic                             redirect_ready_i,
    output logic                             redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]            redirect_addr_o,
    output logic                             csr_mtvec_init_o,
    output logic                             illegal_sel_o,
    output logic [7:0]                       drop_cnt_o
);

    localparam int TBW = ADDR_WIDTH - VEC_W - 3;

    localparam logic [3:0] PC_BOOT      = 4'b0000;
    localparam logic [3:0] PC_FENCEI    = 4'b0001;
    localparam logic [3:0] PC_JUMP      = 4'b0010;
    localparam logic [3:0] PC_BRANCH    = 4'b0011;
    localparam logic [3:0] PC_EXCEPTION = 4'b0100;
    localparam logic [3:0] PC_MRET      = 4'b0101;
    localparam logic [3:0] PC_URET      = 4'b0110;
    localparam logic [3:0] PC_DRET      = 4'b0111;
    localparam logic [3:0] PC_HWLOOP    = 4'b1000;

    localparam logic [2:0] EXC_PC_EXCEPTION = 3'b000;
    localparam logic [2:0] EXC_PC_IRQ       = 3'b001;
    localparam logic [2:0] EXC_PC_DBD       = 3'b010;
    localparam logic [2:0] EXC_PC_DBE       = 3'b011;

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_PEND
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_is_boot;
    logic                    r_init;
    logic                    r_illegal;
    logic [7:0]              r_drop_cnt;

    logic                    w_trap_bad;
    logic                    w_priv_bad;
    logic [PRIV_W-1:0]       w_tidx;
    logic [PRIV_W-1:0]       w_eidx;
    logic [TBW-1:0]          w_base;
    logic [VEC_W-1:0]        w_vec;
    logic [ADDR_WIDTH-1:0]   w_epc;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic [ADDR_WIDTH-1:0]   w_boot_tgt;
    logic                    w_mux_ok;
    logic                    w_uses_trap;
    logic                    w_req;
    logic                    w_load;
    logic [ADDR_WIDTH-1:0]   w_load_addr;
    logic                    w_load_boot;
    logic                    w_drop;
    logic                    w_unused;

    assign w_unused = ^{xret_priv_i, boot_addr_i[1:0],
                        dm_halt_addr_i[1:0], dm_exception_addr_i[1:0]};

    // Out-of-range privilege levels fall back to machine level
    assign w_trap_bad = 32'(trap_priv_i) >= NUM_PRIV;
    assign w_tidx     = w_trap_bad ? '0 : trap_priv_i;
    assign w_eidx     = (pc_mux_i == PC_URET && NUM_PRIV > 1) ? PRIV_W'(1) : '0;
    assign w_base     = trap_base_addr_i[32'(w_tidx)*TBW +: TBW];
    assign w_vec      = exc_vec_i[32'(w_tidx)*VEC_W +: VEC_W];
    assign w_epc      = epc_i[32'(w_eidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_boot_tgt = {boot_addr_i[ADDR_WIDTH-1:2], 2'b00};

    assign w_uses_trap = (pc_mux_i == PC_EXCEPTION) &&
                         (exc_pc_mux_i != EXC_PC_DBD) &&
                         (exc_pc_mux_i != EXC_PC_DBE);
    assign w_priv_bad  = (w_uses_trap && w_trap_bad) ||
                         (pc_mux_i == PC_URET && NUM_PRIV < 2);

    always_comb begin
        w_target = '0;
        w_mux_ok = 1'b1;
        unique case (pc_mux_i)
            PC_BOOT:   w_target = w_boot_tgt;
            PC_FENCEI: w_target = pc_id_i + ADDR_WIDTH'(4);
            PC_JUMP:   w_target = jump_target_id_i;
            PC_BRANCH: w_target = jump_target_ex_i;
            PC_MRET:   w_target = w_epc;
            PC_URET:   w_target = w_epc;
            PC_DRET:   w_target = depc_i;
            PC_HWLOOP: w_target = hwlp_target_i;
            PC_EXCEPTION: begin
                unique case (exc_pc_mux_i)
                    EXC_PC_IRQ:
                        w_target = {w_base, 1'b0, w_vec, 2'b00};
                    EXC_PC_DBD:
                        w_target = {dm_halt_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    EXC_PC_DBE:
                        w_target = {dm_exception_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    EXC_PC_EXCEPTION:
                        w_target = {w_base, {(VEC_W+3){1'b0}}};
                    default:
                        w_target = {w_base, {(VEC_W+3){1'b0}}};
                endcase
            end
            default: w_mux_ok = 1'b0;
        endcase
    end

    assign w_req = pc_set_i & w_mux_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_BOOT: w_state_nxt = S_PEND;
            S_IDLE: if (w_req) w_state_nxt = S_PEND;
            S_PEND: if (!w_req && redirect_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // A request arriving in the boot cycle takes precedence over the boot target
    always_comb begin
        w_load      = 1'b0;
        w_load_addr = w_target;
        w_load_boot = (pc_mux_i == PC_BOOT);
        w_drop      = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_load = 1'b1;
                if (!w_req) begin
                    w_load_addr = w_boot_tgt;
                    w_load_boot = 1'b1;
                end
            end
            S_IDLE: w_load = w_req;
            S_PEND: begin
                w_load = w_req;
                w_drop = w_req & ~redirect_ready_i;
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_is_boot  <= 1'b0;
            r_init     <= 1'b0;
            r_illegal  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_valid   <= (w_state_nxt == S_PEND);
            r_init    <= r_valid & redirect_ready_i & r_is_boot;
            r_illegal <= pc_set_i & (~w_mux_ok | w_priv_bad);
            if (w_load) begin
                r_addr    <= w_load_addr;
                r_is_boot <= w_load_boot;
            end
            if (w_drop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign redirect_valid_o = r_valid;
    assign redirect_addr_o  = r_addr;
    assign csr_mtvec_init_o = r_init;
    assign illegal_sel_o    = r_illegal;
    assign drop_cnt_o       = r_drop_cnt;

endmodule

// File: tb/tb_cv32e40p_pc_redirect_unit.sv
// Bench for cv32e40p_pc_redirect_unit: directed plan steps plus random
// traffic checked against a transaction-level reference model.
module tb_cv32e40p_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_set_i = 1'b0;
    logic [3:0]  pc_mux_i = '0;
    logic [2:0]  exc_pc_mux_i = '0;
    logic [1:0]  trap_priv_i = '0;
    logic [1:0]  xret_priv_i = '0;
    logic [23:0] base [2];
    logic [4:0]  vec [2];
    logic [31:0] epc [2];
    logic [31:0] boot_addr_i = '0;
    logic [31:0] dm_halt_addr_i = '0;
    logic [31:0] dm_exception_addr_i = '0;
    logic [31:0] jump_target_id_i = '0;
    logic [31:0] jump_target_ex_i = '0;
    logic [31:0] depc_i = '0;
    logic [31:0] pc_id_i = '0;
    logic [31:0] hwlp_target_i = '0;
    logic        redirect_ready_i = 1'b0;
    logic        redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        csr_mtvec_init_o;
    logic        illegal_sel_o;
    logic [7:0]  drop_cnt_o;

    logic [47:0] w_base_bus;
    logic [9:0]  w_vec_bus;
    logic [63:0] w_epc_bus;
    assign w_base_bus = {base[1], base[0]};
    assign w_vec_bus  = {vec[1], vec[0]};
    assign w_epc_bus  = {epc[1], epc[0]};

    cv32e40p_pc_redirect_unit #(
        .ADDR_WIDTH(32), .VEC_W(5), .NUM_PRIV(2), .PRIV_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_set_i(pc_set_i), .pc_mux_i(pc_mux_i),
        .exc_pc_mux_i(exc_pc_mux_i), .trap_priv_i(trap_priv_i),
        .xret_priv_i(xret_priv_i), .trap_base_addr_i(w_base_bus),
        .exc_vec_i(w_vec_bus), .epc_i(w_epc_bus),
        .boot_addr_i(boot_addr_i), .dm_halt_addr_i(dm_halt_addr_i),
        .dm_exception_addr_i(dm_exception_addr_i),
        .jump_target_id_i(jump_target_id_i),
        .jump_target_ex_i(jump_target_ex_i), .depc_i(depc_i),
        .pc_id_i(pc_id_i), .hwlp_target_i(hwlp_target_i),
        .redirect_ready_i(redirect_ready_i),
        .redirect_valid_o(redirect_valid_o),
        .redirect_addr_o(redirect_addr_o),
        .csr_mtvec_init_o(csr_mtvec_init_o),
        .illegal_sel_o(illegal_sel_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: one held redirect plus side counters
    logic        m_boot;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_isboot;
    int          m_drop;
    logic        m_init;
    logic        m_ill;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_target();
        int p;
        p = (trap_priv_i < 2) ? int'(trap_priv_i) : 0;
        case (pc_mux_i)
            4'd0: return boot_addr_i & ~32'd3;
            4'd1: return pc_id_i + 32'd4;
            4'd2: return jump_target_id_i;
            4'd3: return jump_target_ex_i;
            4'd4: begin
                case (exc_pc_mux_i)
                    3'd1: return 32'(base[p]) * 256 + 32'(vec[p]) * 4;
                    3'd2: return dm_halt_addr_i & ~32'd3;
                    3'd3: return dm_exception_addr_i & ~32'd3;
                    default: return 32'(base[p]) * 256;
                endcase
            end
            4'd5: return epc[0];
            4'd6: return epc[1];
            4'd7: return depc_i;
            4'd8: return hwlp_target_i;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        logic        req;
        logic [31:0] tgt;
        req = pc_set_i && (pc_mux_i <= 4'd8);
        tgt = ref_target();
        m_ill = pc_set_i && ((pc_mux_i > 4'd8) ||
                (pc_mux_i == 4'd4 && exc_pc_mux_i != 3'd2 &&
                 exc_pc_mux_i != 3'd3 && trap_priv_i >= 2));
        m_init = m_valid && redirect_ready_i && m_isboot;
        if (m_boot) begin
            m_addr   = req ? tgt : (boot_addr_i & ~32'd3);
            m_isboot = req ? (pc_mux_i == 4'd0) : 1'b1;
            m_valid  = 1'b1;
        end else if (req) begin
            if (m_valid && !redirect_ready_i && m_drop < 255) m_drop++;
            m_addr   = tgt;
            m_isboot = (pc_mux_i == 4'd0);
            m_valid  = 1'b1;
        end else if (m_valid && redirect_ready_i) begin
            m_valid = 1'b0;
        end
        m_boot = 1'b0;
        @(posedge clk);
        #1;
        chk("valid", 32'(redirect_valid_o), 32'(m_valid));
        chk("addr", redirect_addr_o, m_addr);
        chk("init", 32'(csr_mtvec_init_o), 32'(m_init));
        chk("illegal", 32'(illegal_sel_o), 32'(m_ill));
        chk("drop", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_addr", redirect_addr_o, 32'd0);
        chk("rst_init", 32'(csr_mtvec_init_o), 32'd0);
        chk("rst_ill", 32'(illegal_sel_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        m_boot = 1'b1; m_valid = 1'b0; m_addr = '0; m_isboot = 1'b0;
        m_drop = 0; m_init = 1'b0; m_ill = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        base[0] = '0; base[1] = '0; vec[0] = '0; vec[1] = '0;
        epc[0] = '0; epc[1] = '0;

        // 1: automatic boot redirect
        boot_addr_i = 32'h1C00_0083;
        redirect_ready_i = 1'b1;
        do_reset();
        step();
        chk("t1_valid", 32'(redirect_valid_o), 32'd1);
        chk("t1_addr", redirect_addr_o, 32'h1C00_0080);
        step();
        chk("t1_init", 32'(csr_mtvec_init_o), 32'd1);
        chk("t1_valid_drop", 32'(redirect_valid_o), 32'd0);

        // 2: vectored IRQ on both levels
        pc_set_i = 1'b1; pc_mux_i = 4'd4; exc_pc_mux_i = 3'd1;
        trap_priv_i = 2'd1; base[1] = 24'h00_1234; vec[1] = 5'd5;
        step();
        chk("t2_irq1", redirect_addr_o, 32'h0012_3414);
        trap_priv_i = 2'd0; base[0] = 24'hABCDEF; vec[0] = 5'd0;
        step();
        chk("t2_irq0", redirect_addr_o, 32'hABCD_EF00);
        pc_set_i = 1'b0;
        step();

        // 3: fence.i wraps
        pc_set_i = 1'b1; pc_mux_i = 4'd1; pc_id_i = 32'hFFFF_FFFC;
        step();
        chk("t3_wrap", redirect_addr_o, 32'h0000_0000);
        pc_set_i = 1'b0;
        step();

        // 4: newest wins while fetch stalls
        redirect_ready_i = 1'b0; pc_set_i = 1'b1;
        pc_mux_i = 4'd2; jump_target_id_i = 32'h100; step();
        pc_mux_i = 4'd3; jump_target_ex_i = 32'h200; step();
        pc_mux_i = 4'd7; depc_i = 32'h300; step();
        chk("t4_addr", redirect_addr_o, 32'h300);
        chk("t4_drop", 32'(drop_cnt_o), 32'd2);
        pc_set_i = 1'b0;
        step();
        redirect_ready_i = 1'b1;
        step();
        chk("t4_accept", 32'(redirect_valid_o), 32'd0);

        // 5: back-to-back redirect without gap
        pc_set_i = 1'b1; pc_mux_i = 4'd2; jump_target_id_i = 32'h400;
        step();
        pc_mux_i = 4'd5; epc[0] = 32'h8000_0040;
        step();
        chk("t5_valid", 32'(redirect_valid_o), 32'd1);
        chk("t5_addr", redirect_addr_o, 32'h8000_0040);
        pc_set_i = 1'b0;
        step();

        // 6: unmapped select and out-of-range level
        pc_set_i = 1'b1; pc_mux_i = 4'hF;
        step();
        chk("t6_ill", 32'(illegal_sel_o), 32'd1);
        chk("t6_novalid", 32'(redirect_valid_o), 32'd0);
        pc_set_i = 1'b0;
        step();
        chk("t6_ill_once", 32'(illegal_sel_o), 32'd0);
        pc_set_i = 1'b1; pc_mux_i = 4'd4; exc_pc_mux_i = 3'd0;
        trap_priv_i = 2'd2; base[0] = 24'h123456;
        step();
        chk("t6_lvl0", redirect_addr_o, 32'h1234_5600);
        chk("t6_ill_priv", 32'(illegal_sel_o), 32'd1);
        pc_set_i = 1'b0; trap_priv_i = 2'd0;
        step();

        // requested PC_BOOT also strobes mtvec init
        pc_set_i = 1'b1; pc_mux_i = 4'd0; boot_addr_i = 32'h0000_2002;
        step();
        pc_set_i = 1'b0;
        step();
        chk("boot_req_init", 32'(csr_mtvec_init_o), 32'd1);

        // drop counter saturation
        redirect_ready_i = 1'b0; pc_set_i = 1'b1; pc_mux_i = 4'd3;
        for (int i = 0; i < 260; i++) begin
            jump_target_ex_i = $urandom;
            step();
        end
        chk("drop_sat", 32'(drop_cnt_o), 32'd255);

        // async reset while a redirect is held
        pc_set_i = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(redirect_valid_o), 32'd0);
        chk("async_drop", 32'(drop_cnt_o), 32'd0);
        pc_set_i = 1'b1; pc_mux_i = 4'd2; jump_target_id_i = 32'h500;
        redirect_ready_i = 1'b1;
        do_reset();
        step();
        chk("boot_override", redirect_addr_o, 32'h500);
        pc_set_i = 1'b0;
        step();
        chk("boot_override_noinit", 32'(csr_mtvec_init_o), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            pc_set_i = ($urandom_range(0, 2) != 0);
            pc_mux_i = ($urandom_range(0, 7) == 0) ?
                       4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            exc_pc_mux_i = 3'($urandom_range(0, 7));
            trap_priv_i = 2'($urandom_range(0, 3));
            xret_priv_i = 2'($urandom_range(0, 3));
            redirect_ready_i = ($urandom_range(0, 2) != 0);
            base[i % 2] = 24'($urandom);
            vec[i % 2] = 5'($urandom);
            epc[i % 2] = $urandom;
            boot_addr_i = $urandom; dm_halt_addr_i = $urandom;
            dm_exception_addr_i = $urandom; jump_target_id_i = $urandom;
            jump_target_ex_i = $urandom; depc_i = $urandom;
            pc_id_i = $urandom; hwlp_target_i = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
